tree_dfs_walker: RTL and testbench
==================================

# tree_dfs_walker

Depth-first traversal engine for binary decision trees held in an on-chip node memory. It is the initiator side of the `stack` push/pop interface: it pushes pending right-child IDs, pops them when a branch finishes, and streams every leaf ID it reaches in left-first order. It sits between the tree node RAM, a `stack` instance (DATA_WIDTH = NODE_W), and the downstream leaf/rule consumer.

## Interface
- NODE_W, 8: node ID width; also the stack data width and the memory address width.
- CNT_W, 16: width of the leaf counter.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to walk from `root_id`; ignored unless idle.
- root_id  in  NODE_W  root node ID, sampled with `start`.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse at the end of a walk.
- err_overflow  out  1  valid with `done`: the walk aborted because the stack was full.
- mem_rd_en  out  1  node memory read strobe.
- mem_addr  out  NODE_W  node ID being read.
- mem_rd_data  in  2*NODE_W+1  node word, valid the cycle after `mem_rd_en`: [2N] is_leaf, [2N-1:N] left ID, [N-1:0] right ID.
- stk_push  out  1  stack push, one cycle.
- stk_wdata  out  NODE_W  push data (the right-child ID).
- stk_pop  out  1  stack pop, one cycle.
- stk_rdata  in  NODE_W  stack data_out.
- stk_just_popped  in  1  stack `just_popped`; qualifies `stk_rdata`.
- stk_full, stk_empty  in  1  stack status flags.
- leaf_valid  out  1  leaf ID offered.
- leaf_id  out  NODE_W  ID of the leaf node.
- leaf_ready  in  1  consumer accepts when `leaf_valid` and `leaf_ready` are both high.
- leaf_count  out  CNT_W  number of leaves accepted in the current or last walk.

## Operation
- States: IDLE, FETCH, DECODE, EMIT, POP, POP_WAIT, DONE.
- IDLE: on `start`, set cur←root_id, clear leaf_count and err_overflow, then go to FETCH.
- FETCH: assert `mem_rd_en` with mem_addr=cur for exactly 1 cycle, then go to DECODE.
- DECODE (mem_rd_data valid):
  - is_leaf=1: go to EMIT.
  - is_leaf=0 and !stk_full: assert stk_push with stk_wdata=right for 1 cycle, set cur←left, go to FETCH.
  - is_leaf=0 and stk_full: no push; set err_overflow=1 and go to DONE.
- EMIT: hold leaf_valid=1 with leaf_id=cur, stable until the handshake completes. On handshake, leaf_count+1 (saturating at all-ones), then go to POP.
- POP:
  - stk_empty=1: go to DONE.
  - otherwise: assert stk_pop for 1 cycle and go to POP_WAIT.
- POP_WAIT: wait for stk_just_popped, then set cur←stk_rdata and go to FETCH. stk_pop stays low while waiting.
- DONE: pulse `done` for 1 cycle, then go to IDLE. err_overflow holds until the next accepted `start`.
- Exclusivity: stk_push and stk_pop are never high in the same cycle. mem_rd_en is high only in FETCH.
- The walker never issues a push while stk_full=1 or a pop while stk_empty=1.
- Precondition: the stack is empty at `start`. The walker does not drain a stack left non-empty by an aborted walk; the system resets the stack.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE.
  - busy, done, err_overflow, mem_rd_en, stk_push, stk_pop, leaf_valid = 0.
  - mem_addr, stk_wdata, leaf_id, leaf_count = 0.
- `start` accepted in cycle T: busy=1 and FETCH at T+1; node data available at T+2 (DECODE).
- Internal node costs 2 cycles (FETCH, DECODE).
- Leaf with leaf_ready held high: EMIT lasts 1 cycle.
- Pop round trip: POP (1 cycle), then POP_WAIT; the `stack` returns just_popped at +1, so the minimum is 2 cycles before the next FETCH.
- Single-leaf root, leaf_ready=1, start at T:
  - leaf_valid at T+3, POP at T+4, DONE/done pulse at T+5, busy=0 at T+6.
- busy drops the cycle after the `done` pulse.
- `start` while busy: ignored, no state change.
- Reset mid-walk: the walk is abandoned immediately. No done pulse; all outputs go to their reset values.

## Test plan
- Single-leaf root (node 5 is_leaf=1), leaf_ready=1 → leaf_id=5 once, done at T+5, leaf_count=1, err_overflow=0, no stk_push.
- Tree: 0→(1,2), 1→(3,4); nodes 2, 3, 4 are leaves → leaf order 3,4,2; pushes 2 then 4; leaf_count=3; stack empty at done.
- Same tree with leaf_ready low for 5 cycles on each offer → leaf_id and leaf_valid held stable, no pop during the stall, same order, leaf_count=3.
- Left-leaning chain of depth 5 with a 2-entry stack (stk_full forced at the 3rd push) → err_overflow=1 with done; only 2 pushes issued; no leaf emitted.
- Reset asserted in POP_WAIT, then start again → outputs at reset values while reset is low; after release, a fresh walk completes normally (stack also reset).
- `start` pulsed while busy with a different root_id → ignored; the original walk's leaves and count are unchanged.

Source files
------------

// File: rtl/tree_dfs_walker.sv
// Depth-first walker for binary decision trees held in node RAM.
// Right children are parked on an external stack while the left branch is
// explored; leaves are streamed out in left-first order.
module tree_dfs_walker #(
  parameter int unsigned NODE_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NODE_W-1:0]   root_id,
  output logic                busy,
  output logic                done,
  output logic                err_overflow,
  output logic                mem_rd_en,
  output logic [NODE_W-1:0]   mem_addr,
  input  logic [2*NODE_W:0]   mem_rd_data,
  output logic                stk_push,
  output logic [NODE_W-1:0]   stk_wdata,
  output logic                stk_pop,
  input  logic [NODE_W-1:0]   stk_rdata,
  input  logic                stk_just_popped,
  input  logic                stk_full,
  input  logic                stk_empty,
  output logic                leaf_valid,
  output logic [NODE_W-1:0]   leaf_id,
  input  logic                leaf_ready,
  output logic [CNT_W-1:0]    leaf_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StEmit,
    StPop,
    StPopWait,
    StDone
  } state_e;

  state_e              state;
  logic [NODE_W-1:0]   cur;

  logic                node_is_leaf;
  logic [NODE_W-1:0]   node_left;
  logic [NODE_W-1:0]   node_right;

  assign node_is_leaf = mem_rd_data[2*NODE_W];
  assign node_left    = mem_rd_data[2*NODE_W-1:NODE_W];
  assign node_right   = mem_rd_data[NODE_W-1:0];

  // Stack strobes depend on same-cycle node data and stack flags, so they are
  // decoded from the registered state rather than registered themselves.
  always_comb begin
    stk_push  = (state == StDecode) && !node_is_leaf && !stk_full;
    stk_wdata = stk_push ? node_right : '0;
    stk_pop   = (state == StPop) && !stk_empty;
  end

  // Walk sequencer with registered status, memory and leaf outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      cur          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      leaf_valid   <= 1'b0;
      leaf_id      <= '0;
      leaf_count   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            cur          <= root_id;
            mem_addr     <= root_id;
            mem_rd_en    <= 1'b1;
            busy         <= 1'b1;
            leaf_count   <= '0;
            err_overflow <= 1'b0;
            state        <= StFetch;
          end
        end
        StFetch: begin
          mem_rd_en <= 1'b0;
          state     <= StDecode;
        end
        StDecode: begin
          if (node_is_leaf) begin
            leaf_valid <= 1'b1;
            leaf_id    <= cur;
            state      <= StEmit;
          end else if (!stk_full) begin
            cur       <= node_left;
            mem_addr  <= node_left;
            mem_rd_en <= 1'b1;
            state     <= StFetch;
          end else begin
            err_overflow <= 1'b1;
            done         <= 1'b1;
            state        <= StDone;
          end
        end
        StEmit: begin
          if (leaf_ready) begin
            leaf_valid <= 1'b0;
            if (leaf_count != {CNT_W{1'b1}}) begin
              leaf_count <= leaf_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            state <= StPop;
          end
        end
        StPop: begin
          if (stk_empty) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            state <= StPopWait;
          end
        end
        StPopWait: begin
          if (stk_just_popped) begin
            cur       <= stk_rdata;
            mem_addr  <= stk_rdata;
            mem_rd_en <= 1'b1;
            state     <= StFetch;
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_dfs_walker.sv
// Scoreboard bench for tree_dfs_walker with node RAM and stack models.
module tb_tree_dfs_walker;

  localparam int NW = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic [NW-1:0]   root_id;
  logic            busy, done, err_overflow, mem_rd_en;
  logic [NW-1:0]   mem_addr;
  logic [2*NW:0]   mem_rd_data;
  logic            stk_push, stk_pop, stk_just_popped, stk_full, stk_empty;
  logic [NW-1:0]   stk_wdata, stk_rdata;
  logic            leaf_valid, leaf_ready;
  logic [NW-1:0]   leaf_id;
  logic [15:0]     leaf_count;

  tree_dfs_walker #(.NODE_W(NW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .root_id(root_id),
    .busy(busy), .done(done), .err_overflow(err_overflow),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .stk_push(stk_push), .stk_wdata(stk_wdata), .stk_pop(stk_pop),
    .stk_rdata(stk_rdata), .stk_just_popped(stk_just_popped),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .leaf_valid(leaf_valid), .leaf_id(leaf_id), .leaf_ready(leaf_ready),
    .leaf_count(leaf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Node RAM: registered read, data valid the cycle after mem_rd_en.
  logic [2*NW:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Stack model with configurable capacity; just_popped one cycle after pop.
  logic [NW-1:0] sdata [0:31];
  int scnt;
  int scap = 16;
  assign stk_full  = (scnt == scap);
  assign stk_empty = (scnt == 0);
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt <= 0;
      stk_just_popped <= 1'b0;
      stk_rdata <= '0;
    end else begin
      stk_just_popped <= 1'b0;
      if (stk_push && scnt < scap) begin
        sdata[scnt] <= stk_wdata;
        scnt <= scnt + 1;
      end else if (stk_pop && scnt > 0) begin
        stk_rdata <= sdata[scnt-1];
        scnt <= scnt - 1;
        stk_just_popped <= 1'b1;
      end
    end
  end

  typedef struct {
    int   cnt;
    logic ovf;
    int   lat;
    int   t0;
  } done_t;

  logic [NW-1:0] exp_leaf_q [$];
  logic [NW-1:0] exp_push_q [$];
  done_t         exp_done_q [$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: left-first walk over the tree in mem with a pending-right list.
  task automatic model_walk(input logic [NW-1:0] root, output logic ovf, output int n);
    logic [NW-1:0] pend [$];
    logic [NW-1:0] cur;
    logic [2*NW:0] w;
    cur = root;
    ovf = 1'b0;
    n = 0;
    for (int it = 0; it < 1000; it++) begin
      w = mem[cur];
      if (w[2*NW]) begin
        exp_leaf_q.push_back(cur);
        n++;
        if (pend.size() == 0) break;
        cur = pend.pop_back();
      end else if (pend.size() >= scap) begin
        ovf = 1'b1;
        break;
      end else begin
        exp_push_q.push_back(w[NW-1:0]);
        pend.push_back(w[NW-1:0]);
        cur = w[2*NW-1:NW];
      end
    end
  endtask

  // leaf_ready behaviour: 0 always ready, 1 random, 2 stall 5 cycles per offer.
  int ready_mode = 0;
  int stall_cnt = 0;
  initial begin
    leaf_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: leaf_ready = 1'b1;
        1: leaf_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!leaf_valid) begin
            stall_cnt = 0;
            leaf_ready = 1'b0;
          end else if (stall_cnt < 5) begin
            stall_cnt++;
            leaf_ready = 1'b0;
          end else begin
            leaf_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: protocol checks and scoreboard pops on every DUT output event.
  initial begin
    logic          stall_prev;
    logic [NW-1:0] stall_id;
    logic          prev_done;
    done_t         d;
    logic [NW-1:0] e;
    stall_prev = 1'b0;
    prev_done = 1'b0;
    stall_id = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (stk_push || stk_pop) chk("push_pop_exclusive", {stk_push, stk_pop} == 2'b11, 0);
        if (stk_push) begin
          chk("push_while_full", stk_full, 0);
          if (exp_push_q.size() == 0) chk("unexpected_push", stk_wdata, 0 - 1);
          else begin
            e = exp_push_q.pop_front();
            chk("push_data", stk_wdata, e);
          end
        end
        if (stk_pop) chk("pop_while_empty_or_emit", stk_empty | leaf_valid, 0);
        if (stall_prev) begin
          chk("stall_valid_held", leaf_valid, 1);
          chk("stall_id_held", leaf_id, stall_id);
        end
        if (leaf_valid && leaf_ready) begin
          if (exp_leaf_q.size() == 0) chk("unexpected_leaf", leaf_id, 0 - 1);
          else begin
            e = exp_leaf_q.pop_front();
            chk("leaf_id", leaf_id, e);
          end
        end
        stall_prev = leaf_valid && !leaf_ready;
        stall_id = leaf_id;
        if (prev_done) chk("busy_drops_after_done", busy, 0);
        if (done) begin
          chk("busy_with_done", busy, 1);
          if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            d = exp_done_q.pop_front();
            chk("leaf_count", leaf_count, d.cnt);
            chk("err_overflow", err_overflow, d.ovf);
            if (!d.ovf) chk("stack_empty_at_done", stk_empty, 1);
            if (d.lat >= 0) chk("done_latency", cyc - d.t0, d.lat);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    chk(name, {busy, done, err_overflow, mem_rd_en, stk_push, stk_pop, leaf_valid,
               mem_addr, stk_wdata, leaf_id, leaf_count}, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_reset_outputs("outputs_in_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_walk(input logic [NW-1:0] root, input int exp_lat, input bit stray);
    logic ovf;
    int n;
    int guard;
    done_t d;
    model_walk(root, ovf, n);
    @(posedge clk);
    #1;
    start = 1'b1;
    root_id = root;
    d.cnt = (n > 65535) ? 65535 : n;
    d.ovf = ovf;
    d.lat = exp_lat;
    d.t0 = cyc;
    exp_done_q.push_back(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    root_id = 8'($urandom);
    chk("busy_after_start", busy, 1);
    if (stray) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      root_id = root ^ 8'h55;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    guard = 0;
    while (busy && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) chk("walk_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("leaf_q_drained", exp_leaf_q.size(), 0);
    chk("push_q_drained", exp_push_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);
    if (ovf) begin
      chk("err_overflow_holds", err_overflow, 1);
      pulse_reset();
    end
    exp_leaf_q.delete();
    exp_push_q.delete();
    exp_done_q.delete();
  endtask

  task automatic set_leaf(input logic [NW-1:0] id);
    mem[id] = {1'b1, 16'($urandom)};
  endtask

  task automatic set_node(input logic [NW-1:0] id, input logic [NW-1:0] l,
                          input logic [NW-1:0] r);
    mem[id] = {1'b0, l, r};
  endtask

  task automatic build_tree3();
    set_node(0, 1, 2);
    set_node(1, 3, 4);
    set_leaf(2);
    set_leaf(3);
    set_leaf(4);
  endtask

  task automatic build_random(output logic [NW-1:0] root);
    logic [NW-1:0] leaves [$];
    logic [NW-1:0] nd, l, r;
    int base, k, idx, nexp;
    base = $urandom_range(0, 255);
    k = 0;
    root = 8'(base);
    k++;
    set_leaf(root);
    leaves.push_back(root);
    nexp = $urandom_range(0, 12);
    for (int i = 0; i < nexp; i++) begin
      idx = $urandom_range(0, leaves.size() - 1);
      nd = leaves[idx];
      leaves.delete(idx);
      l = 8'(base + k);
      r = 8'(base + k + 1);
      k += 2;
      set_node(nd, l, r);
      set_leaf(l);
      set_leaf(r);
      leaves.push_back(l);
      leaves.push_back(r);
    end
  endtask

  initial begin
    logic [NW-1:0] rt;
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = {1'b1, 16'h0};
    reset = 1'b0;
    start = 1'b0;
    root_id = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b1;

    // Single-leaf root.
    ready_mode = 0;
    scap = 16;
    set_leaf(5);
    run_walk(8'd5, 5, 1'b0);

    // Three-leaf tree, always ready, then with 5-cycle stalls.
    build_tree3();
    run_walk(8'd0, -1, 1'b0);
    ready_mode = 2;
    run_walk(8'd0, -1, 1'b0);

    // Left-leaning chain against a 2-entry stack.
    ready_mode = 0;
    scap = 2;
    for (int i = 0; i < 4; i++) begin
      set_node(8'(20 + i), 8'(21 + i), 8'(30 + i));
      set_leaf(8'(30 + i));
    end
    set_leaf(8'd24);
    run_walk(8'd20, -1, 1'b0);

    // Reset while waiting on a pop, then a fresh walk.
    scap = 16;
    build_tree3();
    begin
      logic ovf;
      int n;
      model_walk(8'd0, ovf, n);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    root_id = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!stk_pop && guard < 200);
    if (guard >= 200) chk("pop_wait_timeout", 1, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_reset_outputs("reset_mid_walk");
    chk("stack_reset", stk_empty, 1);
    exp_leaf_q.delete();
    exp_push_q.delete();
    exp_done_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_walk(8'd0, -1, 1'b0);

    // start pulsed while busy is ignored.
    ready_mode = 1;
    set_leaf(8'h55);
    run_walk(8'd0, -1, 1'b1);

    // Random trees, random back-pressure and stack capacity.
    for (int t = 0; t < 25; t++) begin
      ready_mode = $urandom_range(0, 2);
      scap = $urandom_range(2, 8);
      build_random(rt);
      run_walk(rt, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
